cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Two-master, one-slave arbiter between the I-cache and D-cache line-refill/write-back ports and the single
//  128-bit main-memory port. Sits directly downstream of both caches.
//  Grants one line transaction at a time, registers its command/address/data, and returns mem_ready/rdata
//  only to the granted cache. Uses the same one-cycle mem_ready handshake the caches already use.
// PARAMETERS
//  ADDR_W  28   line address width (word address >> 2)
//  DATA_W  128  line data width
// PORTS
//  clk           in   1       clock, rising edge
//  proc_reset_n  in   1       reset, asynchronous, active-low
//  i_mem_read    in   1       I-cache line read request (I port is read-only)
//  i_mem_addr    in   ADDR_W  I-cache line address
//  i_mem_rdata   out  DATA_W  line data to I-cache, valid when i_mem_ready=1
//  i_mem_ready   out  1       one-cycle completion pulse to I-cache
//  d_mem_read    in   1       D-cache line read request
//  d_mem_write   in   1       D-cache line write-back request (never together with d_mem_read)
//  d_mem_addr    in   ADDR_W  D-cache line address
//  d_mem_wdata   in   DATA_W  D-cache write-back data
//  d_mem_rdata   out  DATA_W  line data to D-cache, valid when d_mem_ready=1
//  d_mem_ready   out  1       one-cycle completion pulse to D-cache
//  mem_read      out  1       memory read strobe
//  mem_write     out  1       memory write strobe
//  mem_addr      out  ADDR_W  memory line address (registered)
//  mem_wdata     out  DATA_W  memory write data (registered)
//  mem_rdata     in   DATA_W  memory read data, valid with mem_ready
//  mem_ready     in   1       memory one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): state=IDLE, last_grant=I, addr/wdata/cmd regs=0; all outputs 0.
//  - States: IDLE, BUSY_I, BUSY_D.
//  - IDLE:
//    - Requests are sampled each cycle.
//    - Grant goes to the winner; addr, wdata and cmd (RD/WR) are latched; next state is BUSY_x.
//    - With no request, stay in IDLE.
//  - BUSY_x:
//    - mem_read  = (cmd==RD) & ~mem_ready.
//    - mem_write = (cmd==WR) & ~mem_ready.
//    - Both strobes are held from the first BUSY cycle until the mem_ready cycle.
//    - On mem_ready, x_mem_ready=1 in the same cycle (combinational pass-through).
//    - x_mem_rdata=mem_rdata; last_grant<=x; next state is IDLE.
//  - Latency: request seen in cycle N -> mem strobe high in N+1.
//    - mem_ready in cycle M -> cache ready in M.
//    - Earliest next grant sampled in M+1, strobe in M+2.
//  - The non-granted master's ready stays 0. Its rdata is a don't-care; drive it 0.
//  - Master dropping its request mid-transaction is ignored; the latched transaction completes.
//  - mem_ready while in IDLE is ignored; no ready is forwarded.
//  - d_mem_read & d_mem_write both high is illegal. Treat it as a write.
//  - Async reset mid-BUSY: immediately IDLE and strobes 0. The pending transaction is abandoned.
//  - D-cache WB->ALLC sequence: the refill read is re-arbitrated as a new request.
//    The I port may win in between under round-robin.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - On simultaneous requests in IDLE, grant goes to the master != last_grant.
//    - A single request always wins.
//  ARB_ROUND_ROBIN_EN undefined:
//    - Fixed priority: D wins every tie.
//    - last_grant is still tracked, but unused.
// STRUCTURE
//  Shared package arb_pkg:
//    - state localparams IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2
//    - master ids M_I=1'b0, M_D=1'b1
//    - cmd codes CMD_RD=1'b0, CMD_WR=1'b1
//  Sub-module arb_grant_sel (combinational):
//    - inputs i_req, d_req, last_grant
//    - outputs grant_valid, grant_id
//    - holds the only ARB_ROUND_ROBIN_EN ifdef
// TESTING
//  1. Reset low mid-BUSY_D write (addr 28'h0000010)
//     -> mem_write drops to 0 the same cycle; state IDLE; readies 0.
//  2. I read only, addr 28'h00000A4; memory ready after 3 cycles with rdata 128'hDEAD...BEEF
//     -> mem_read high 3 cycles; i_mem_ready pulse with that data; d_mem_ready stays 0.
//  3. I read and D write simultaneous, RR enabled, last_grant=I
//     -> D granted first; mem_addr/wdata = D values; I granted next, mem_read in M+2.
//  4. Same tie with macro undefined, last_grant=D
//     -> D still granted first.
//  5. D write-back then refill (addr 28'h0000123, I idle)
//     -> WR completes, then RD to 28'h0000123.
//     -> d_mem_ready pulses twice, once per transaction.
//  6. Master drops d_mem_read after 1 BUSY cycle, and spurious mem_ready in IDLE
//     -> transaction completes with d_mem_ready; spurious pulse produces no ready and no state change.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM states, master ids and command codes.
// Round-robin vs fixed-priority arbitration is selected by the ARB_ROUND_ROBIN_EN macro.
package arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic M_I    = 1'b0;
  localparam logic M_D    = 1'b1;
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection between the I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN defined: ties go to the master that was not granted last; otherwise D wins ties.
module arb_grant_sel
  import arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_id = M_I;
    if (i_req && d_req) grant_id = ~last_grant;
    else if (d_req)     grant_id = M_D;
  end
`else
  // Fixed priority keeps last_grant in the interface so both builds share one port list.
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;
  assign grant_id = d_req ? M_D : M_I;
`endif
endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-master (I-cache, D-cache) to one main-memory port line arbiter with registered command/address/data.
// Handshake: a granted transaction is held on mem_read/mem_write until the single-cycle mem_ready, which is
// passed through to the granted cache in that same cycle. Tie policy selected by ARB_ROUND_ROBIN_EN.
module cache_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        o_dbg_state
);
  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_grant_valid;
  logic w_grant_id;
  logic w_d_wr;
  logic w_busy;

  arb_grant_sel u_grant_sel (
    .i_req       (i_mem_read),
    .d_req       (d_mem_read | d_mem_write),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // A simultaneous read+write from the D-cache is treated as a write.
  assign w_d_wr = (w_grant_id == M_D) && d_mem_write;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= M_I;
      r_cmd        <= CMD_RD;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state <= (w_grant_id == M_D) ? BUSY_D : BUSY_I;
            r_addr  <= (w_grant_id == M_D) ? d_mem_addr : i_mem_addr;
            r_cmd   <= w_d_wr ? CMD_WR : CMD_RD;
            r_wdata <= w_d_wr ? d_mem_wdata : '0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            r_last_grant <= M_I;
            r_state      <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            r_last_grant <= M_D;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy      = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign mem_read    = w_busy && (r_cmd == CMD_RD) && !mem_ready;
  assign mem_write   = w_busy && (r_cmd == CMD_WR) && !mem_ready;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign i_mem_ready = (r_state == BUSY_I) && mem_ready;
  assign d_mem_ready = (r_state == BUSY_D) && mem_ready;
  assign i_mem_rdata = i_mem_ready ? mem_rdata : '0;
  assign d_mem_rdata = d_mem_ready ? mem_rdata : '0;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; tie expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset_n;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_BUSYI = 2'd1;
  localparam logic [1:0]    S_BUSYD = 2'd2;
  localparam logic [DW-1:0] RDATA_A = 128'hDEADBEEF_00112233_44556677_DEADBEEF;
  localparam logic [DW-1:0] RDATA_B = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
  localparam logic [DW-1:0] WDATA_A = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
  localparam logic [DW-1:0] WDATA_B = 128'hFEEDFACE_11112222_33334444_55556666;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .i_mem_read   (i_mem_read),
    .i_mem_addr   (i_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_addr   (d_mem_addr),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_ready  (d_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a memory completion for one cycle; the caller has already dropped the cache request.
  task automatic mem_done(input logic [DW-1:0] data, input string tag, input logic exp_i, input logic exp_d);
    mem_ready = 1'b1;
    mem_rdata = data;
    #1;
    check({tag, "_i_ready"}, DW'(i_mem_ready), DW'(exp_i));
    check({tag, "_d_ready"}, DW'(d_mem_ready), DW'(exp_d));
    check({tag, "_i_rdata"}, i_mem_rdata, exp_i ? data : '0);
    check({tag, "_d_rdata"}, d_mem_rdata, exp_d ? data : '0);
    check({tag, "_strobes_low"}, DW'({mem_read, mem_write}), '0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    check({tag, "_back_idle"}, DW'(o_dbg_state), DW'(S_IDLE));
  endtask

  initial begin
    logic [1:0] exp_tie_state;
    proc_reset_n = 1'b0;
    i_mem_read = 1'b0; i_mem_addr = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) tick();
    check("rst_state", DW'(o_dbg_state), DW'(S_IDLE));
    check("rst_strobes", DW'({mem_read, mem_write, i_mem_ready, d_mem_ready}), '0);
    check("rst_addr", DW'(mem_addr), '0);
    proc_reset_n = 1'b1;
    tick();

    // 1: async reset during a D write
    d_mem_write = 1'b1; d_mem_addr = 28'h0000010; d_mem_wdata = WDATA_A;
    tick();
    check("t1_state", DW'(o_dbg_state), DW'(S_BUSYD));
    check("t1_write", DW'(mem_write), DW'(1'b1));
    check("t1_addr", DW'(mem_addr), DW'(28'h0000010));
    check("t1_wdata", mem_wdata, WDATA_A);
    #2 proc_reset_n = 1'b0;
    #1;
    check("t1_rst_write", DW'(mem_write), '0);
    check("t1_rst_state", DW'(o_dbg_state), DW'(S_IDLE));
    check("t1_rst_ready", DW'({i_mem_ready, d_mem_ready}), '0);
    check("t1_rst_addr", DW'(mem_addr), '0);
    d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    tick();
    proc_reset_n = 1'b1;
    tick();

    // 2: I read only, memory answers after three strobe cycles
    i_mem_read = 1'b1; i_mem_addr = 28'h00000A4;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_read_c%0d", k), DW'(mem_read), DW'(1'b1));
      check($sformatf("t2_ready_c%0d", k), DW'({i_mem_ready, d_mem_ready}), '0);
      if (k < 2) tick();
    end
    check("t2_addr", DW'(mem_addr), DW'(28'h00000A4));
    tick();
    i_mem_read = 1'b0;
    mem_done(RDATA_A, "t2", 1'b1, 1'b0);

    // 3: tie with last_grant=I -> D write first, then I read
    i_mem_read = 1'b1; i_mem_addr = 28'h0000200;
    d_mem_write = 1'b1; d_mem_addr = 28'h0000300; d_mem_wdata = WDATA_B;
    tick();
    check("t3_state", DW'(o_dbg_state), DW'(S_BUSYD));
    check("t3_write", DW'({mem_read, mem_write}), DW'(2'b01));
    check("t3_addr", DW'(mem_addr), DW'(28'h0000300));
    check("t3_wdata", mem_wdata, WDATA_B);
    d_mem_write = 1'b0;
    mem_done(RDATA_B, "t3d", 1'b0, 1'b1);
    check("t3_m1_noread", DW'(mem_read), '0);
    tick();
    check("t3_m2_read", DW'(mem_read), DW'(1'b1));
    check("t3_i_addr", DW'(mem_addr), DW'(28'h0000200));
    check("t3_i_wdata", mem_wdata, '0);
    i_mem_read = 1'b0;
    mem_done(RDATA_A, "t3i", 1'b1, 1'b0);

    // 4: make last_grant=D, then tie on reads
    d_mem_read = 1'b1; d_mem_addr = 28'h0000044;
    tick();
    d_mem_read = 1'b0;
    mem_done(RDATA_B, "t4pre", 1'b0, 1'b1);
    i_mem_read = 1'b1; i_mem_addr = 28'h0000055;
    d_mem_read = 1'b1; d_mem_addr = 28'h0000066;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_tie_state = S_BUSYI;
`else
    exp_tie_state = S_BUSYD;
`endif
    check("t4_state", DW'(o_dbg_state), DW'(exp_tie_state));
    check("t4_addr", DW'(mem_addr), (exp_tie_state == S_BUSYD) ? DW'(28'h0000066) : DW'(28'h0000055));
    if (exp_tie_state == S_BUSYD) d_mem_read = 1'b0; else i_mem_read = 1'b0;
    mem_done(RDATA_A, "t4a", exp_tie_state == S_BUSYI, exp_tie_state == S_BUSYD);
    tick();
    check("t4_loser_state", DW'(o_dbg_state), (exp_tie_state == S_BUSYD) ? DW'(S_BUSYI) : DW'(S_BUSYD));
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    mem_done(RDATA_B, "t4b", exp_tie_state == S_BUSYD, exp_tie_state == S_BUSYI);

    // 5: D write-back followed by refill of the same line
    d_mem_write = 1'b1; d_mem_addr = 28'h0000123; d_mem_wdata = WDATA_A;
    tick();
    check("t5_wr", DW'({mem_read, mem_write}), DW'(2'b01));
    check("t5_wr_addr", DW'(mem_addr), DW'(28'h0000123));
    d_mem_write = 1'b0;
    mem_done(RDATA_B, "t5wr", 1'b0, 1'b1);
    d_mem_read = 1'b1;
    tick();
    check("t5_rd", DW'({mem_read, mem_write}), DW'(2'b10));
    check("t5_rd_addr", DW'(mem_addr), DW'(28'h0000123));
    d_mem_read = 1'b0;
    mem_done(RDATA_A, "t5rd", 1'b0, 1'b1);

    // 6: request dropped mid-transaction, spurious mem_ready in IDLE, read+write as write
    d_mem_read = 1'b1; d_mem_addr = 28'h0000777;
    tick();
    d_mem_read = 1'b0;
    tick();
    check("t6_held_state", DW'(o_dbg_state), DW'(S_BUSYD));
    check("t6_held_read", DW'(mem_read), DW'(1'b1));
    mem_done(RDATA_B, "t6", 1'b0, 1'b1);
    mem_ready = 1'b1; mem_rdata = RDATA_A;
    #1;
    check("t6_spur_ready", DW'({i_mem_ready, d_mem_ready}), '0);
    check("t6_spur_rdata", i_mem_rdata | d_mem_rdata, '0);
    tick();
    check("t6_spur_state", DW'(o_dbg_state), DW'(S_IDLE));
    mem_ready = 1'b0; mem_rdata = '0;
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_addr = 28'h0000888; d_mem_wdata = WDATA_B;
    tick();
    check("t6_rw_is_write", DW'({mem_read, mem_write}), DW'(2'b01));
    check("t6_rw_wdata", mem_wdata, WDATA_B);
    d_mem_read = 1'b0; d_mem_write = 1'b0;
    mem_done(RDATA_A, "t6rw", 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
